// File: rtl/stepdown_loop_sequencer.sv
// Stepdown converter PWM sequencer: non-overlapping high/low-side gate enables
// with dead time, soft-start duty ramp and cycle-by-cycle current limit.
module stepdown_loop_sequencer #(
   parameter int PERIOD   = 20,
   parameter int DEADTIME = 2,
   parameter int SS_DIV   = 2
) (
   input  logic       CELCLK,
   input  logic       CELRST,
   input  logic       en,
   input  logic [7:0] duty_cmd,
   input  logic       ilim,
   output logic       hs_on,
   output logic       ls_on,
   output logic       ss_done,
   output logic       ilim_hit
);

   localparam logic [7:0] PMAX    = 8'(PERIOD - 1);
   localparam logic [7:0] DT_LAST = 8'(DEADTIME - 1);
   localparam logic [7:0] DMAX    = 8'(PERIOD - 2 * DEADTIME - 1);
   localparam logic [7:0] SS_LAST = 8'(SS_DIV - 1);

   typedef enum logic [2:0] {IDLE, DT_H, HS, DT_L, LS, SKIP} state_t;

   state_t     state_reg, state_next;
   logic [7:0] pcnt_reg, pcnt_next;
   logic [7:0] dcnt_reg, dcnt_next;
   logic [7:0] ss_lim_reg, ss_lim_next;
   logic [7:0] sscnt_reg, sscnt_next;
   logic [7:0] duty_lat_reg, duty_lat_next;
   logic [7:0] duty_eff;
   logic       ilim_meta_reg, ilim_s_reg;
   logic       period_end;
   logic       ss_done_next, hs_on_next, ls_on_next, ilim_hit_next;

   // Period counter, soft-start limit and per-period duty latch
   always_comb begin
      period_end  = ((state_reg == LS) || (state_reg == SKIP)) && (pcnt_reg == PMAX);
      pcnt_next   = ((state_reg == IDLE) || period_end) ? 8'd0 : pcnt_reg + 8'd1;
      ss_lim_next = ss_lim_reg;
      sscnt_next  = sscnt_reg;
      if (period_end) begin
         if (sscnt_reg == SS_LAST) begin
            sscnt_next = 8'd0;
            if ((ss_lim_reg < duty_cmd) && (ss_lim_reg != 8'hFF))
               ss_lim_next = ss_lim_reg + 8'd1;
         end else begin
            sscnt_next = sscnt_reg + 8'd1;
         end
      end
      if (state_reg == IDLE) begin
         ss_lim_next = 8'd0;
         sscnt_next  = 8'd0;
      end
      // The freshly updated limit applies to the period about to start
      duty_eff = duty_cmd;
      if (ss_lim_next < duty_eff) duty_eff = ss_lim_next;
      if (DMAX < duty_eff)        duty_eff = DMAX;
      duty_lat_next = (period_end || (state_reg == IDLE)) ? duty_eff : duty_lat_reg;
      ss_done_next  = ss_done | (ss_lim_next >= duty_cmd);
      if (!en) begin
         pcnt_next     = 8'd0;
         ss_lim_next   = 8'd0;
         sscnt_next    = 8'd0;
         duty_lat_next = 8'd0;
         ss_done_next  = 1'b0;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     state_next = (duty_eff != 8'd0) ? DT_H : SKIP;
         DT_H:     if (dcnt_reg == DT_LAST) state_next = HS;
         HS:       if (ilim_s_reg || (dcnt_reg == duty_lat_reg - 8'd1)) state_next = DT_L;
         DT_L:     if (dcnt_reg == DT_LAST) state_next = LS;
         LS, SKIP: if (period_end) state_next = (duty_eff != 8'd0) ? DT_H : SKIP;
         default:  state_next = IDLE;
      endcase
      if (!en) state_next = IDLE;
      dcnt_next = (state_next != state_reg) ? 8'd0 : dcnt_reg + 8'd1;
   end

   always_comb begin
      hs_on_next    = (state_next == HS);
      ls_on_next    = (state_next == LS);
      ilim_hit_next = en && (state_reg == HS) && ilim_s_reg;
   end

   always_ff @(posedge CELCLK or posedge CELRST) begin
      if (CELRST) begin
         state_reg     <= IDLE;
         pcnt_reg      <= 8'd0;
         dcnt_reg      <= 8'd0;
         ss_lim_reg    <= 8'd0;
         sscnt_reg     <= 8'd0;
         duty_lat_reg  <= 8'd0;
         ilim_meta_reg <= 1'b0;
         ilim_s_reg    <= 1'b0;
         hs_on         <= 1'b0;
         ls_on         <= 1'b0;
         ss_done       <= 1'b0;
         ilim_hit      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pcnt_reg      <= pcnt_next;
         dcnt_reg      <= dcnt_next;
         ss_lim_reg    <= ss_lim_next;
         sscnt_reg     <= sscnt_next;
         duty_lat_reg  <= duty_lat_next;
         ilim_meta_reg <= ilim;
         ilim_s_reg    <= ilim_meta_reg;
         hs_on         <= hs_on_next;
         ls_on         <= ls_on_next;
         ss_done       <= ss_done_next;
         ilim_hit      <= ilim_hit_next;
      end
   end

endmodule
